bus_alu: RTL and testbench
==========================

# bus_alu

Bus-attached execution unit that sits directly downstream of the microcoded control sequencer on the shared 32-bit tristate bus. It holds an operand latch A and a result register R. Under `alu_wr` it either captures a bus value into A or computes `R = A op bus`. Under `alu_rd` it drives R back onto the bus. Shifts run iteratively, one bit per clock, and `alu_busy` is exported so the sequencer can stall.

## Interface
Parameters:
- `WIDTH`, 32, datapath and bus width.
- `SHAMT_W`, 5, shift-amount width, taken from `bus[SHAMT_W-1:0]`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `bus`  inout  WIDTH  shared system bus; driven only while `alu_rd`=1, high-Z otherwise.
- `alu_wr`  in  1  sample `bus` at posedge `clk` and perform `alu_op`.
- `alu_rd`  in  1  drive R onto `bus`, combinational.
- `alu_op`  in  4  operation select.
- `alu_busy`  out  1  iterative shift in progress.
- `alu_zero`  out  1  R == 0, combinational from R.

## Operation
- Reset values: A=0, R=0, shift counter=0, `alu_busy`=0, `alu_zero`=1, `bus` high-Z.
- `alu_op` encoding:
  - 0000 LOAD: A ← bus; R unchanged.
  - 1000 ADD: R ← A+bus.
  - 1001 SUB: R ← A−bus.
  - 1010 AND, 1011 OR, 1100 XOR.
  - 0001 SLT: R ← {31'b0, signed(A)<signed(bus)}.
  - 0010 SLTU: R ← {31'b0, A<bus}.
  - 1101 SLL, 1110 SRL, 1111 SRA.
  - All other codes: no-op; A and R hold.
- Arithmetic is modulo 2^WIDTH. Carry and overflow are discarded.
- Shifts:
  - At the `alu_wr` edge: R ← A, counter ← bus[4:0], `alu_busy` ← (bus[4:0]≠0).
  - At each following edge while busy: R shifts by one position (SRA replicates bit 31) and the counter decrements.
  - `alu_busy` clears at the edge where the counter reaches 0.
- `alu_wr` while `alu_busy`=1 is ignored: no change to A, R or the counter.
- `alu_rd` while busy drives the partial R. It is legal but the value is undefined for the sequencer's purposes.
- `alu_rd` and `alu_wr` in the same cycle: the bus carries R_old, so the result is R ← A op R_old. This is a defined accumulate idiom.
- Reset asserted mid-shift aborts immediately to reset values.

## Timing
- Control signals settle after negedge `clk`. All ALU state updates on posedge `clk`.
- Single-cycle ops: R is valid on the first negedge after the `alu_wr` posedge. Typical use: `alu_wr` in step n, `alu_rd` in step n+1.
- Shift latency: shamt clocks after the `alu_wr` edge. `alu_busy` is high for exactly shamt cycles. A shamt of 0 takes 0 extra cycles.
- Bus drive is combinational on `alu_rd`, with no added cycle. The block never drives `bus` during reset.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum containing the codes above.
  - `ALU_WIDTH` and `ALU_SHAMT_W` constants.
  - Shared with the control sequencer, which replaces its literal 4'b1000 / 4'b0000 codes with the enum.
- One sub-module, `alu_shifter`: holds R's shift path, the counter, busy generation and the SRA sign fill. The top level holds A, the combinational op mux, the R write arbitration and the tristate.

## Test plan
- Reset mid-shift:
  - Start SLL with shamt=20, assert `rst` at cycle 5 → `alu_busy`=0, R=0, `bus` high-Z in the same cycle.
  - Then LOAD 7 and ADD 1 → R=8.
- LOAD / ADD / SUB with wrap:
  - LOAD 0xFFFFFFFF, ADD 0x00000002 → R=0x00000001, `alu_zero`=0.
  - LOAD 5, SUB 5 → R=0, `alu_zero`=1.
- Compare ops:
  - LOAD 0xFFFFFFFF, SLT 1 → R=1.
  - Same A, SLTU 1 → R=0.
- SRA iterative shift:
  - LOAD 0x80000000, SRA 4 → `alu_busy` high exactly 4 cycles, then R=0xF8000000.
  - SRA 0 → busy never rises, R=A next cycle.
  - An `alu_wr` ADD issued during busy is ignored.
- Bus discipline and accumulate:
  - `alu_rd`=0 → `bus` Z.
  - `alu_rd`=1 with R=0x1234 → `bus`=0x1234.
  - `alu_rd` and `alu_wr` ADD together with A=1, R=0x1234 → R=0x1235.
- Sequencer integration (LW address computation):
  - imm=−4 via LOAD, rs1=0x100 via ADD, then `alu_rd` → bus=0x000000FC in step 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes and sizing shared by bus_alu and the control sequencer
package alu_pkg;
  localparam int ALU_WIDTH   = 32;
  localparam int ALU_SHAMT_W = 5;
  typedef enum logic [3:0] {
    OP_LOAD = 4'b0000,
    OP_SLT  = 4'b0001,
    OP_SLTU = 4'b0010,
    OP_ADD  = 4'b1000,
    OP_SUB  = 4'b1001,
    OP_AND  = 4'b1010,
    OP_OR   = 4'b1011,
    OP_XOR  = 4'b1100,
    OP_SLL  = 4'b1101,
    OP_SRL  = 4'b1110,
    OP_SRA  = 4'b1111
  } alu_op_e;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: one-bit-per-clock shift sequencing for the R register
//   start : load shift kind and count (R itself is loaded from A by the top)
//   shamt : shift amount, kind : OP_SLL / OP_SRL / OP_SRA
//   r     : current R, r_sh : R moved one position, busy : shift in progress
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SHAMT_W-1:0] shamt,
  input  alu_op_e            kind,
  input  logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic [WIDTH-1:0]   r_sh
);
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  alu_op_e            kind_q, kind_d;
  always_comb begin
    kind_d = start ? kind : kind_q;
    cnt_d  = start ? shamt : busy_q ? cnt_q - 1'b1 : cnt_q;
    // busy drops on the edge that consumes the last count
    busy_d = start ? (shamt != '0) : busy_q && (cnt_q != SHAMT_W'(1));
    r_sh   = kind_q == OP_SLL ? {r[WIDTH-2:0], 1'b0} :
             kind_q == OP_SRL ? {1'b0, r[WIDTH-1:1]} :
                                {r[WIDTH-1], r[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      kind_q <= OP_SLL;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      kind_q <= kind_d;
    end
  end
  assign busy = busy_q;
endmodule

// File: rtl/bus_alu.sv
// bus_alu: bus-attached ALU with operand latch A, result register R, iterative shifts
//   bus      : shared tristate bus, driven with R only while alu_rd (and not in reset)
//   alu_wr   : sample bus and perform alu_op at posedge clk (ignored while busy)
//   alu_rd   : drive R onto bus, alu_busy : shift in progress, alu_zero : R == 0
module bus_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             alu_wr,
  input  logic             alu_rd,
  input  logic [3:0]       alu_op,
  output logic             alu_busy,
  output logic             alu_zero
);
  logic [WIDTH-1:0] a_q, a_d, r_q, r_d, r_sh, b;
  alu_op_e          op;
  logic             wr_en, is_shift;
  assign op       = alu_op_e'(alu_op);
  assign wr_en    = alu_wr && !alu_busy;
  assign is_shift = op == OP_SLL || op == OP_SRL || op == OP_SRA;
  // During alu_rd the bus carries our own R, so take it directly (accumulate idiom)
  assign b        = alu_rd ? r_q : bus;
  assign bus      = (alu_rd && !rst) ? r_q : 'z;
  assign alu_zero = r_q == '0;
  alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .start(wr_en && is_shift),
    .shamt(b[SHAMT_W-1:0]),
    .kind (op),
    .r    (r_q),
    .busy (alu_busy),
    .r_sh (r_sh)
  );
  always_comb begin
    a_d = a_q;
    r_d = alu_busy ? r_sh : r_q;
    if (wr_en)
      case (op)
        OP_LOAD: a_d = b;
        OP_ADD:  r_d = a_q + b;
        OP_SUB:  r_d = a_q - b;
        OP_AND:  r_d = a_q & b;
        OP_OR:   r_d = a_q | b;
        OP_XOR:  r_d = a_q ^ b;
        OP_SLT:  r_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b)};
        OP_SLTU: r_d = {{(WIDTH-1){1'b0}}, a_q < b};
        OP_SLL, OP_SRL, OP_SRA: r_d = a_q;
        default: ;
      endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      r_q <= '0;
    end else begin
      a_q <= a_d;
      r_q <= r_d;
    end
  end
endmodule

// File: tb/tb_bus_alu.sv
// tb_bus_alu: vector table, directed corner sequences and random model check for bus_alu
module tb_bus_alu;
  logic        clk = 0, rst = 1, alu_wr = 0, alu_rd = 0, alu_busy, alu_zero;
  logic [3:0]  alu_op = 0;
  logic [31:0] tb_drv = 0;
  logic        tb_en = 1;
  wire  [31:0] bus;
  int          tests = 0, fails = 0;
  assign bus = tb_en ? tb_drv : 'z;
  bus_alu dut (
    .clk(clk), .rst(rst), .bus(bus), .alu_wr(alu_wr), .alu_rd(alu_rd),
    .alu_op(alu_op), .alu_busy(alu_busy), .alu_zero(alu_zero)
  );
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, r;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic [3:0] op, input logic [31:0] v);
    alu_wr = 1; alu_op = op; tb_drv = v; tb_en = 1;
    @(negedge clk);
    alu_wr = 0;
  endtask
  task automatic step_acc(input logic [3:0] op);
    tb_en = 0; alu_rd = 1; alu_wr = 1; alu_op = op;
    @(negedge clk);
    alu_wr = 0; alu_rd = 0; tb_en = 1;
  endtask
  task automatic rd(output logic [31:0] v);
    tb_en = 0; alu_rd = 1;
    #1 v = bus;
    alu_rd = 0; tb_en = 1;
  endtask
  task automatic wait_busy(output int n);
    n = 0;
    while (alu_busy && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] r);
    int sh = int'(b[4:0]);
    case (op)
      4'h8: return a + b;
      4'h9: return a - b;
      4'hA: return a & b;
      4'hB: return a | b;
      4'hC: return a ^ b;
      4'h1: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'h2: return (a < b) ? 1 : 0;
      4'hD: return a << sh;
      4'hE: return a >> sh;
      4'hF: return $unsigned($signed(a) >>> sh);
      default: return r;
    endcase
  endfunction
  initial begin
    logic [31:0] v, a_m, r_m, b;
    logic [3:0]  op;
    int          n, sh;
    bit          acc;
    vecs.push_back('{"add_wrap",  4'h8, 32'hFFFFFFFF, 32'h00000002, 32'h00000001});
    vecs.push_back('{"sub_zero",  4'h9, 32'h00000005, 32'h00000005, 32'h00000000});
    vecs.push_back('{"sub_wrap",  4'h9, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    vecs.push_back('{"slt_neg",   4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{"sltu_big",  4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{"slt_max",   4'h1, 32'h7FFFFFFF, 32'h80000000, 32'h00000000});
    vecs.push_back('{"and",       4'hA, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0});
    vecs.push_back('{"or",        4'hB, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0});
    vecs.push_back('{"xor",       4'hC, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F});
    vecs.push_back('{"sll31",     4'hD, 32'h00000001, 32'h0000001F, 32'h80000000});
    vecs.push_back('{"srl31",     4'hE, 32'h80000000, 32'h0000001F, 32'h00000001});
    vecs.push_back('{"sra4",      4'hF, 32'h80000000, 32'h00000004, 32'hF8000000});
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_busy", 32'(alu_busy), 0);
    chk("reset_zero", 32'(alu_zero), 1);
    rd(v); chk("reset_r", v, 0);
    foreach (vecs[i]) begin
      step(4'h0, vecs[i].a);
      step(vecs[i].op, vecs[i].b);
      wait_busy(n);
      chk({vecs[i].name, "_cycles"}, n,
          (vecs[i].op >= 4'hD) ? 32'(vecs[i].b[4:0]) : 0);
      rd(v); chk(vecs[i].name, v, vecs[i].r);
      chk({vecs[i].name, "_zero"}, 32'(alu_zero), 32'(vecs[i].r == 0));
    end
    step(4'h0, 32'h1);
    step(4'hD, 32'd20);
    repeat (4) @(negedge clk);
    #2 rst = 1;
    #1 chk("rst_mid_busy", 32'(alu_busy), 0);
    chk("rst_mid_zero", 32'(alu_zero), 1);
    @(negedge clk);
    rst = 0;
    step(4'h0, 32'd7);
    step(4'h8, 32'd1);
    rd(v); chk("post_rst_add", v, 32'd8);
    step(4'h0, 32'h80000000);
    step(4'hF, 32'd4);
    chk("sra_busy_rise", 32'(alu_busy), 1);
    step(4'h8, 32'd5);
    wait_busy(n);
    chk("sra_ignored_cycles", n, 3);
    rd(v); chk("sra_ignored_r", v, 32'hF8000000);
    step(4'h8, 32'd0);
    rd(v); chk("a_kept", v, 32'h80000000);
    step(4'h0, 32'h0000ABCD);
    step(4'hF, 32'd0);
    chk("sra0_busy", 32'(alu_busy), 0);
    rd(v); chk("sra0_r", v, 32'h0000ABCD);
    step(4'h0, 32'h1234);
    step(4'h8, 32'd0);
    step(4'h0, 32'd1);
    tb_drv = 0; tb_en = 1; alu_rd = 0;
    #1 chk("bus_released", bus, 0);
    rd(v); chk("bus_drive", v, 32'h1234);
    step_acc(4'h8);
    rd(v); chk("accumulate", v, 32'h1235);
    step(4'h0, 32'hFFFFFFFC);
    step(4'h8, 32'h100);
    rd(v); chk("lw_addr", v, 32'h000000FC);
    step(4'h0, 0);
    step(4'h8, 0);
    a_m = 0; r_m = 0;
    for (int i = 0; i < 300; i++) begin
      op  = 4'($urandom_range(0, 15));
      v   = $urandom;
      acc = $urandom_range(0, 7) == 0;
      b   = acc ? r_m : v;
      sh  = (op >= 4'hD) ? int'(b[4:0]) : 0;
      r_m = ref_op(op, a_m, b, r_m);
      if (op == 4'h0) a_m = b;
      if (acc) step_acc(op); else step(op, v);
      wait_busy(n);
      chk("rand_cycles", n, sh);
      rd(v); chk("rand_r", v, r_m);
      chk("rand_zero", 32'(alu_zero), 32'(r_m == 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
